// File: rtl/eth_tx_framer.sv
// Byte-stream Ethernet TX framer: preamble/SFD, payload, zero pad to MIN_LEN, optional FCS, IFG.
// Define SM_ETH_FCS_EN to build the CRC-32 logic and append the 4-byte FCS.
module eth_tx_framer #(
    parameter int MIN_LEN    = 60,
    parameter int IFG_CYCLES = 192
) (
    input  logic       eth_clk,
    input  logic       eth_rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy
);
    localparam int                 IFG_W   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0]   IFG_END = IFG_W'(IFG_CYCLES - 1);
    localparam logic [10:0]        MIN_L   = 11'(MIN_LEN);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
`ifdef SM_ETH_FCS_EN
        FCS,
`endif
        IFG
    } state_t;

    state_t           state, state_nx;
    logic [7:0]       data_nx;
    logic             valid_nx, last_nx;
    logic             tail, tail_nx;
    logic [10:0]      cnt, cnt_nx, cnt_inc;
    logic [2:0]       sub, sub_nx;
    logic [IFG_W-1:0] ifg_cnt, ifg_nx;
    logic             can_load;

`ifdef SM_ETH_FCS_EN
    logic [31:0] crc, crc_nx, crc_inv;

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int unsigned i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    assign crc_inv = ~crc;
`endif

    assign can_load = !m_valid || m_ready;
    assign cnt_inc  = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
    assign busy     = (state != IDLE);

    // tail marks that the m_last byte is loaded; the frame ends on its handshake.
    always_comb begin
        state_nx = state;
        data_nx  = m_data;
        valid_nx = m_valid;
        last_nx  = m_last;
        tail_nx  = tail;
        cnt_nx   = cnt;
        sub_nx   = sub;
        ifg_nx   = ifg_cnt;
`ifdef SM_ETH_FCS_EN
        crc_nx   = crc;
`endif
        s_ready  = 1'b0;

        if (m_valid && m_ready) begin
            valid_nx = 1'b0;
            last_nx  = 1'b0;
        end

        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_nx = PRE;
                    cnt_nx   = '0;
                    sub_nx   = '0;
                    tail_nx  = 1'b0;
`ifdef SM_ETH_FCS_EN
                    crc_nx   = '1;
`endif
                end
            end
            PRE: begin
                if (can_load) begin
                    data_nx  = 8'h55;
                    valid_nx = 1'b1;
                    if (sub == 3'd6) begin
                        sub_nx   = '0;
                        state_nx = SFD;
                    end else begin
                        sub_nx = sub + 3'd1;
                    end
                end
            end
            SFD: begin
                if (can_load) begin
                    data_nx  = 8'hD5;
                    valid_nx = 1'b1;
                    state_nx = DATA;
                end
            end
            DATA: begin
                s_ready = can_load && !tail;
                if (s_valid && can_load && !tail) begin
                    data_nx  = s_data;
                    valid_nx = 1'b1;
                    cnt_nx   = cnt_inc;
`ifdef SM_ETH_FCS_EN
                    crc_nx   = crc_step(crc, s_data);
`endif
                    if (s_last) begin
                        if (cnt_inc < MIN_L) begin
                            state_nx = PAD;
                        end else begin
`ifdef SM_ETH_FCS_EN
                            state_nx = FCS;
`else
                            last_nx  = 1'b1;
                            tail_nx  = 1'b1;
`endif
                        end
                    end
                end
            end
            PAD: begin
                if (can_load && !tail) begin
                    data_nx  = 8'h00;
                    valid_nx = 1'b1;
                    cnt_nx   = cnt_inc;
`ifdef SM_ETH_FCS_EN
                    crc_nx   = crc_step(crc, 8'h00);
                    if (cnt_inc >= MIN_L)
                        state_nx = FCS;
`else
                    if (cnt_inc >= MIN_L) begin
                        last_nx = 1'b1;
                        tail_nx = 1'b1;
                    end
`endif
                end
            end
`ifdef SM_ETH_FCS_EN
            FCS: begin
                if (can_load && !tail) begin
                    data_nx  = crc_inv[{sub[1:0], 3'b000} +: 8];
                    valid_nx = 1'b1;
                    if (sub == 3'd3) begin
                        last_nx = 1'b1;
                        tail_nx = 1'b1;
                        sub_nx  = '0;
                    end else begin
                        sub_nx = sub + 3'd1;
                    end
                end
            end
`endif
            IFG: begin
                if (ifg_cnt == IFG_END)
                    state_nx = IDLE;
                else
                    ifg_nx = ifg_cnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase

        if (tail && m_valid && m_ready) begin
            state_nx = IFG;
            tail_nx  = 1'b0;
            ifg_nx   = '0;
        end
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            state   <= IDLE;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            tail    <= 1'b0;
            cnt     <= '0;
            sub     <= '0;
            ifg_cnt <= '0;
`ifdef SM_ETH_FCS_EN
            crc     <= '1;
`endif
        end else begin
            state   <= state_nx;
            m_data  <= data_nx;
            m_valid <= valid_nx;
            m_last  <= last_nx;
            tail    <= tail_nx;
            cnt     <= cnt_nx;
            sub     <= sub_nx;
            ifg_cnt <= ifg_nx;
`ifdef SM_ETH_FCS_EN
            crc     <= crc_nx;
`endif
        end
    end
endmodule
